// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the SDRAM port arbiter
package sdram_arb_pkg;

  localparam int ADDR_W_DEF = 25;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// rtl/sdram_arb_pick.sv - combinational winner select; SDRAM_ARB_ROUND_ROBIN_EN alternates under contention
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic any,
  output logic winner
);

  assign any = valid0 | valid1;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    if (valid0 && valid1) begin
      winner = ~last_grant;
    end else begin
      winner = valid0 ? PORT_CPU : PORT_DMA;
    end
  end
`else
  // Fixed priority: last_grant is tracked upstream but has no effect here.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    winner = valid0 ? PORT_CPU : PORT_DMA;
  end
`endif

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-master arbiter onto one SDRAM native port; SDRAM_ARB_ROUND_ROBIN_EN selects round-robin
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_din,
  input  logic [DATA_W/8-1:0]   m0_wmask,
  input  logic                  m0_valid,
  output logic [DATA_W-1:0]     m0_dout,
  output logic                  m0_ready,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_din,
  input  logic [DATA_W/8-1:0]   m1_wmask,
  input  logic                  m1_valid,
  output logic [DATA_W-1:0]     m1_dout,
  output logic                  m1_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_din,
  output logic [DATA_W/8-1:0]   mem_wmask,
  output logic                  mem_valid,
  input  logic [DATA_W-1:0]     mem_dout,
  input  logic                  mem_ready,
  output logic                  busy
);

  state_t state;
  state_t next_state;
  logic   grant;
  logic   last_grant;
  logic   is_write;
  logic   any;
  logic   winner;

  sdram_arb_pick u_pick (
    .valid0     (m0_valid),
    .valid1     (m1_valid),
    .last_grant (last_grant),
    .any        (any),
    .winner     (winner)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any) next_state = BUSY;
      BUSY:    if (mem_ready) next_state = GAP;
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // GAP holds mem_valid low for one cycle and clears the ready pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_wmask  <= '0;
      mem_valid  <= 1'b0;
      m0_dout    <= '0;
      m1_dout    <= '0;
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
      grant      <= PORT_CPU;
      last_grant <= PORT_DMA;
      is_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            mem_addr  <= (winner == PORT_DMA) ? m1_addr  : m0_addr;
            mem_din   <= (winner == PORT_DMA) ? m1_din   : m0_din;
            mem_wmask <= (winner == PORT_DMA) ? m1_wmask : m0_wmask;
            is_write  <= (winner == PORT_DMA) ? (|m1_wmask) : (|m0_wmask);
            mem_valid <= 1'b1;
            grant     <= winner;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_valid  <= 1'b0;
            last_grant <= grant;
            if (grant == PORT_DMA) begin
              m1_ready <= 1'b1;
              if (!is_write) m1_dout <= mem_dout;
            end else begin
              m0_ready <= 1'b1;
              if (!is_write) m0_dout <= mem_dout;
            end
          end
        end
        GAP: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
        end
        default: begin
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Two-requester arbiter that shares one SDRAM controller's 32-bit native port between a primary master (m0, CPU) and a secondary master (m1, DMA/video).
- Serialises requests and registers all downstream payload.
- Routes read data and the completion pulse back to the granted master.
- Guarantees the one-cycle valid-low gap the downstream port requires between transactions.

Parameters:
ADDR_W, 25, byte-address width of the masters and the memory port
DATA_W, 32, data width; wmask width is DATA_W/8

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
m0_addr  in  ADDR_W  master 0 byte address
m0_din  in  DATA_W  master 0 write data
m0_wmask  in  DATA_W/8  master 0 byte enables; all-zero means read
m0_valid  in  1  master 0 request
m0_dout  out  DATA_W  master 0 read data
m0_ready  out  1  master 0 one-cycle completion pulse
m1_addr, m1_din, m1_wmask, m1_valid, m1_dout, m1_ready  same as m0, for master 1
mem_addr  out  ADDR_W  registered address to the controller
mem_din  out  DATA_W  registered write data
mem_wmask  out  DATA_W/8  registered byte enables
mem_valid  out  1  request to the controller
mem_dout  in  DATA_W  controller read data
mem_ready  in  1  controller one-cycle completion pulse
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (clk is the clock; resetn is synchronous, active-low):
  - All outputs 0. State IDLE. grant=0. last_grant=1.
- Master protocol:
  - Master holds valid and payload stable until its ready pulse.
  - Master deasserts valid, or presents a new request, in the cycle after the pulse.
- Memory protocol:
  - mem_valid and payload stay constant from issue until mem_ready.
  - mem_valid is low for at least one full cycle between transactions.
- FSM IDLE:
  - If any m*_valid is high: select the winner, latch the winner's addr/din/wmask into mem_*, set mem_valid<=1, record grant and write flag (|wmask), go to BUSY.
  - Otherwise stay in IDLE.
- FSM BUSY:
  - Hold all mem_* outputs.
  - On mem_ready: mem_valid<=0 and m{grant}_ready<=1.
  - On a read, also load m{grant}_dout<=mem_dout. On a write, m{grant}_dout keeps its previous value.
  - Set last_grant<=grant, then go to GAP.
- FSM GAP:
  - m*_ready<=0, go to IDLE. This is exactly 1 cycle; the master drops or replaces its valid during it.
- Ignored inputs:
  - mem_ready in IDLE and GAP is ignored.
  - Requests arriving during BUSY or GAP wait; there is no queue.
- Latency:
  - m_valid sampled in IDLE at cycle 0 → mem_valid high from cycle 1.
  - mem_ready at cycle k → m_ready and m_dout valid at cycle k+1.
  - Earliest next mem_valid is cycle k+3.
- Ready outputs: exactly one of m0_ready/m1_ready pulses per transaction, width 1 cycle. The two are never high together.
- Default arbitration: fixed priority, m0 wins simultaneous requests. m1 can starve under continuous m0 traffic; this is accepted without the optional feature.
- Reset mid-transaction: the transaction is abandoned, outputs return to reset values, and no ready pulse is issued. The controller shares the same reset.
- Address and data pass through unmodified. No width conversion.

Optional Feature:
SDRAM_ARB_ROUND_ROBIN_EN
- Defined: simultaneous requests are granted to the port != last_grant, so both ports alternate under contention. Port 0 wins the first contention after reset (last_grant resets to 1).
- Undefined: fixed priority to m0. last_grant is still maintained but unused.

Decomposition:
- Package sdram_arb_pkg holds:
  - state enum (IDLE, BUSY, GAP);
  - port-index constants (PORT_CPU=0, PORT_DMA=1);
  - ADDR_W/DATA_W defaults.
- One natural sub-module: sdram_arb_pick, combinational winner selection from valids and last_grant, with the round-robin option inside.
- The FSM and payload registers stay in the top.

Test Plan:
- m0 read addr 0x0000100; controller model returns 0xDEADBEEF with mem_ready 4 cycles after mem_valid → mem_addr=0x0000100, mem_wmask=0; m0_ready one pulse exactly 1 cycle after mem_ready; m0_dout=0xDEADBEEF; m1_ready stays 0.
- m1 write addr 0x1FFFFFC, din 0x12345678, wmask 4'b0110 → mem_* match the request and stay stable until mem_ready; m1_ready one pulse; m1_dout unchanged.
- m0 and m1 valid in the same cycle, macro undefined → m0 served first, m1 served next. mem_valid is low for ≥1 cycle between them.
- Both masters request continuously for 6 transactions, macro defined → grant order 0,1,0,1,0,1.
- Spurious mem_ready pulse in IDLE → no m*_ready pulse, no state change.
- resetn low while in BUSY → next cycle mem_valid=0, busy=0, no ready pulse. A request after reset completes normally.
